// File: rtl/pad_command_queue_if.sv
// Command handshake between the pad command queue and the robot motion logic.
interface pad_command_queue_if;
  logic       cmd_valid;
  logic [3:0] cmd_code;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_code, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/pad_command_queue.sv
// Per-frame button debounce, press/auto-repeat event generation, and a small
// command FIFO feeding the motion logic through a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for pending events
// SCAN  | walking pending bits 11..0, one per cycle, pushing set bits
module pad_command_queue #(
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int REPEAT_DELAY    = 30,
  parameter int REPEAT_PERIOD   = 6,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                 clock_50,
  input  logic                 reset,
  input  logic                 vga_vs,
  input  logic [11:0]          buttons,
  output logic [11:0]          btn_state,
  output logic                 overflow,
  pad_command_queue_if.master  cmd
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, SCAN} state_t;

  logic        vs_q1, vs_q2, tick;
  logic [2:0]  db_cnt [12];
  logic [7:0]  hold_cnt [4];
  logic [7:0]  hold_inc [4];
  logic [11:0] flip, press_evt, repeat_evt, events, pending, clear;
  state_t      state, state_nxt;
  logic [3:0]  idx, idx_nxt;
  logic [3:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic        push, pop, accept;

  // Falling edge of the synchronised vsync is the frame tick.
  assign tick = !vs_q1 && vs_q2;

  always_comb begin
    flip = '0;
    for (int i = 0; i < 12; i++)
      flip[i] = tick && (buttons[i] != btn_state[i]) &&
                ((db_cnt[i] + 3'd1) == 3'(DEBOUNCE_FRAMES));
  end

  assign press_evt = flip & buttons;

  always_comb begin
    repeat_evt = '0;
    hold_inc   = '{default: '0};
    for (int d = 0; d < 4; d++) begin
      hold_inc[d]       = hold_cnt[d] + 8'd1;
      repeat_evt[8 + d] = tick && btn_state[8 + d] &&
                          (hold_inc[d] == 8'(REPEAT_DELAY));
    end
  end

  assign events = press_evt | repeat_evt;

  always_ff @(posedge clock_50) begin
    if (!reset) begin
      vs_q1     <= 1'b0;
      vs_q2     <= 1'b0;
      btn_state <= '0;
      pending   <= '0;
      for (int i = 0; i < 12; i++) db_cnt[i] <= '0;
      for (int d = 0; d < 4; d++) hold_cnt[d] <= '0;
    end else begin
      vs_q1 <= vga_vs;
      vs_q2 <= vs_q1;
      if (tick) begin
        for (int i = 0; i < 12; i++) begin
          if (buttons[i] == btn_state[i]) begin
            db_cnt[i] <= '0;
          end else if (flip[i]) begin
            db_cnt[i]    <= '0;
            btn_state[i] <= ~btn_state[i];
          end else begin
            db_cnt[i] <= db_cnt[i] + 3'd1;
          end
        end
      end
      for (int d = 0; d < 4; d++) begin
        if (!btn_state[8 + d])
          hold_cnt[d] <= '0;
        else if (tick)
          hold_cnt[d] <= repeat_evt[8 + d] ? 8'(REPEAT_DELAY - REPEAT_PERIOD)
                                           : hold_inc[d];
      end
      // New events win over a same-cycle clear of the bit being scanned.
      pending <= (pending & ~clear) | events;
    end
  end

  always_ff @(posedge clock_50) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Entering SCAN on the tick edge itself lets index 11 be pushed one cycle later.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    clear     = '0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if ((pending | events) != '0) begin
          state_nxt = SCAN;
          idx_nxt   = 4'd11;
        end
      end
      SCAN: begin
        if (pending[idx]) begin
          push       = 1'b1;
          clear[idx] = 1'b1;
        end
        if (idx == 4'd0) state_nxt = IDLE;
        else             idx_nxt   = idx - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd.cmd_valid = (count != '0);
  assign cmd.cmd_code  = cmd.cmd_valid ? mem[rd_ptr] : 4'd0;
  assign pop           = cmd.cmd_valid && cmd.cmd_ready;
  assign accept        = push && ((count < (PW+1)'(FIFO_DEPTH)) || pop);

  always_ff @(posedge clock_50) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= idx;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !accept) overflow <= 1'b1;
    end
  end

endmodule
